button_entry_conditioner: RTL and testbench

Front-end for the door code FSM. It synchronises and debounces the two code buttons and a separate enter button, and commits one 2-bit symbol per clean enter press. It drives the FSM's bn input with a single-cycle sym_valid strobe, tracks position within the 4-symbol code, and aborts a stalled entry on timeout.

---
 rtl/door_pkg.sv | 24 ++
 rtl/button_entry_conditioner_if.sv | 27 ++
 rtl/debounce_sync.sv | 36 +++
 rtl/button_entry_conditioner.sv | 130 +++++++++++++
 tb/tb_button_entry_conditioner.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/door_pkg.sv
// Shared types and defaults for the door-code button entry front-end.
package door_pkg;

    // Width of one committed code symbol.
    localparam int unsigned SYM_W = 2;

    // Default timing, assuming a 100 MHz clock.
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int unsigned TIMEOUT_CYCLES_DEF  = 500000000;
    localparam int unsigned SEQ_LEN_DEF         = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ENTRY = 1'b1
    } state_e;

    typedef logic [SYM_W:1] sym_t;

    // Sequence index width; kept at least one bit so a 1-symbol code still has a port.
    function automatic int unsigned idx_width(input int unsigned seq_len);
        return (seq_len > 1) ? $clog2(seq_len) : 1;
    endfunction

endpackage

// File: rtl/button_entry_conditioner_if.sv
// Button inputs and committed-symbol outputs of the entry conditioner.
//   btn_raw, btn_enter_raw : raw asynchronous buttons (master drives)
//   bn, sym_valid, sym_idx, seq_done, entry_timeout, busy : conditioner results
interface button_entry_conditioner_if
    import door_pkg::*;
#(
    parameter int unsigned IDX_W = 2
);
    logic [SYM_W:1]   btn_raw;
    logic             btn_enter_raw;
    logic [SYM_W:1]   bn;
    logic             sym_valid;
    logic [IDX_W-1:0] sym_idx;
    logic             seq_done;
    logic             entry_timeout;
    logic             busy;

    modport master (
        output btn_raw, btn_enter_raw,
        input  bn, sym_valid, sym_idx, seq_done, entry_timeout, busy
    );

    modport slave (
        input  btn_raw, btn_enter_raw,
        output bn, sym_valid, sym_idx, seq_done, entry_timeout, busy
    );
endinterface

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a level debouncer.
//   clock, clear_n : clock and async active-low reset
//   raw            : asynchronous input
//   stable         : debounced level, changes after DEBOUNCE_CYCLES+2 edges of a settled input
module debounce_sync #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic clear_n,
    input  logic raw,
    output logic stable
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt;

    // Any sample equal to the accepted level restarts the hold count.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            sync_q <= 2'b00;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            if (sync_q[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync_q[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/button_entry_conditioner.sv
// Conditions code and enter buttons and commits one symbol per clean enter press.
//   clock, clear_n : clock and async active-low reset
//   bus (slave)    : raw buttons in; bn/sym_valid/sym_idx/seq_done/entry_timeout/busy out
module button_entry_conditioner
    import door_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
    parameter int unsigned SEQ_LEN         = SEQ_LEN_DEF
) (
    input logic                       clock,
    input logic                       clear_n,
    button_entry_conditioner_if.slave bus
);
    localparam int unsigned IDX_W = idx_width(SEQ_LEN);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

    logic [2:0] raw_vec;
    logic [2:0] stable_vec;
    logic       enter_prev;
    logic       commit_c;

    state_e           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [TMR_W-1:0] timer, timer_n;
    sym_t             bn_n;
    logic [IDX_W-1:0] sym_idx_n;
    logic             sym_valid_n, seq_done_n, timeout_n, busy_n;

    // Bit 2 is enter; bits 1:0 are code buttons 2 and 1.
    assign raw_vec = {bus.btn_enter_raw, bus.btn_raw};

    for (genvar i = 0; i < 3; i++) begin : g_db
        debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clock  (clock),
            .clear_n(clear_n),
            .raw    (raw_vec[i]),
            .stable (stable_vec[i])
        );
    end

    // A commit is the rising edge of the debounced enter level.
    assign commit_c = stable_vec[2] & ~enter_prev;

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        timer_n     = timer;
        bn_n        = bus.bn;
        sym_idx_n   = bus.sym_idx;
        sym_valid_n = 1'b0;
        seq_done_n  = 1'b0;
        timeout_n   = 1'b0;
        busy_n      = (state == ENTRY);

        if (commit_c) begin
            sym_valid_n = 1'b1;
            bn_n        = stable_vec[1:0];
            sym_idx_n   = idx;
        end

        case (state)
            IDLE: begin
                idx_n   = '0;
                timer_n = '0;
                if (commit_c) begin
                    if (SEQ_LEN > 1) begin
                        idx_n   = IDX_W'(1);
                        state_n = ENTRY;
                    end else begin
                        seq_done_n = 1'b1;
                    end
                end
            end
            ENTRY: begin
                // A commit on the expiry cycle takes priority over the timeout.
                if (commit_c) begin
                    timer_n = '0;
                    if (idx == IDX_W'(SEQ_LEN - 1)) begin
                        seq_done_n = 1'b1;
                        idx_n      = '0;
                        state_n    = IDLE;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_n = 1'b1;
                    idx_n     = '0;
                    timer_n   = '0;
                    state_n   = IDLE;
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
                timer_n = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state             <= IDLE;
            idx               <= '0;
            timer             <= '0;
            enter_prev        <= 1'b0;
            bus.bn            <= '0;
            bus.sym_valid     <= 1'b0;
            bus.sym_idx       <= '0;
            bus.seq_done      <= 1'b0;
            bus.entry_timeout <= 1'b0;
            bus.busy          <= 1'b0;
        end else begin
            state             <= state_n;
            idx               <= idx_n;
            timer             <= timer_n;
            enter_prev        <= stable_vec[2];
            bus.bn            <= bn_n;
            bus.sym_valid     <= sym_valid_n;
            bus.sym_idx       <= sym_idx_n;
            bus.seq_done      <= seq_done_n;
            bus.entry_timeout <= timeout_n;
            bus.busy          <= busy_n;
        end
    end
endmodule

// File: tb/tb_button_entry_conditioner.sv
module tb_button_entry_conditioner;
    import door_pkg::*;

    localparam int D = 4;
    localparam int T = 20;
    localparam int S = 4;
    localparam int LAT = D + 3;   // raw enter rise to sym_valid

    logic clock;
    logic clear_n;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    button_entry_conditioner_if #(.IDX_W(idx_width(S))) dif();

    button_entry_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .TIMEOUT_CYCLES (T),
        .SEQ_LEN        (S)
    ) dut (
        .clock  (clock),
        .clear_n(clear_n),
        .bus    (dif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Event logs sampled on the falling edge.
    int   sv_cyc[$];
    int   sv_bn[$];
    int   sv_idx[$];
    int   sv_sd[$];
    int   sd_cyc[$];
    int   to_cyc[$];
    logic busy_at[int];

    always @(negedge clock) begin
        busy_at[cyc] = dif.busy;
        if (dif.sym_valid === 1'b1) begin
            sv_cyc.push_back(cyc);
            sv_bn.push_back(int'(dif.bn));
            sv_idx.push_back(int'(dif.sym_idx));
            sv_sd.push_back(int'(dif.seq_done));
        end
        if (dif.seq_done === 1'b1) sd_cyc.push_back(cyc);
        if (dif.entry_timeout === 1'b1) to_cyc.push_back(cyc);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_logs();
        sv_cyc.delete(); sv_bn.delete(); sv_idx.delete(); sv_sd.delete();
        sd_cyc.delete(); to_cyc.delete();
    endtask

    // Clean press: code set, enter rises 2 cycles later (pc), held, then all released.
    task automatic press(input logic [2:1] code, input int hold, input int gap, output int pc);
        dif.btn_raw = code;
        tick(2);
        dif.btn_enter_raw = 1'b1;
        pc = cyc;
        tick(hold);
        dif.btn_enter_raw = 1'b0;
        dif.btn_raw = 2'b00;
        tick(gap);
    endtask

    task automatic test_reset();
        clear_n = 1'b0;
        dif.btn_raw = 2'b00;
        dif.btn_enter_raw = 1'b0;
        tick(3);
        tests_run++;
        if ({dif.bn, dif.sym_valid, dif.sym_idx, dif.seq_done, dif.entry_timeout, dif.busy} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got bn=%b v=%b idx=%0d sd=%b to=%b busy=%b, expected all 0",
                     dif.bn, dif.sym_valid, dif.sym_idx, dif.seq_done, dif.entry_timeout, dif.busy);
        end
        clear_n = 1'b1;
        tick(5);
        tests_run++;
        if (dif.sym_valid !== 1'b0 || dif.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: got v=%b busy=%b, expected 0 0", dif.sym_valid, dif.busy);
        end
    endtask

    task automatic test_bounce();
        int pc;
        clear_logs();
        dif.btn_raw = 2'b10;
        tick(2);
        repeat (3) begin
            dif.btn_enter_raw = 1'b1; tick(2);
            dif.btn_enter_raw = 1'b0; tick(2);
        end
        dif.btn_enter_raw = 1'b1;
        pc = cyc;
        tick(30);
        dif.btn_enter_raw = 1'b0;
        dif.btn_raw = 2'b00;
        tick(12);
        tests_run++;
        if (sv_cyc.size() !== 1) begin
            tests_failed++;
            $display("FAIL bounce_count: got %0d sym_valid, expected 1", sv_cyc.size());
        end else begin
            tests_run++;
            if (sv_cyc[0] !== pc + LAT || sv_bn[0] !== 2 || sv_idx[0] !== 0) begin
                tests_failed++;
                $display("FAIL bounce_commit: got cyc=%0d bn=%0d idx=%0d, expected cyc=%0d bn=2 idx=0",
                         sv_cyc[0], sv_bn[0], sv_idx[0], pc + LAT);
            end
            tests_run++;
            if (busy_at[sv_cyc[0]] !== 1'b0 || busy_at[sv_cyc[0] + 1] !== 1'b1) begin
                tests_failed++;
                $display("FAIL bounce_busy: got %b then %b, expected 0 then 1",
                         busy_at[sv_cyc[0]], busy_at[sv_cyc[0] + 1]);
            end
        end
    endtask

    task automatic test_sequence();
        int pc[5];
        logic [2:1] codes[5];
        codes[0] = 2'b11; codes[1] = 2'b01; codes[2] = 2'b00; codes[3] = 2'b10; codes[4] = 2'b11;
        clear_logs();
        for (int i = 0; i < 5; i++) press(codes[i], 8, (i == 4) ? 30 : 8, pc[i]);
        tests_run++;
        if (sv_cyc.size() !== 5) begin
            tests_failed++;
            $display("FAIL seq_count: got %0d sym_valid, expected 5", sv_cyc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests_run++;
                if (sv_cyc[i] !== pc[i] + LAT || sv_bn[i] !== int'(codes[i]) ||
                    sv_idx[i] !== (i % S) || sv_sd[i] !== int'(i == S - 1)) begin
                    tests_failed++;
                    $display("FAIL seq_sym%0d: got cyc=%0d bn=%0d idx=%0d sd=%0d, expected cyc=%0d bn=%0d idx=%0d sd=%0d",
                             i, sv_cyc[i], sv_bn[i], sv_idx[i], sv_sd[i],
                             pc[i] + LAT, codes[i], i % S, int'(i == S - 1));
                end
            end
            tests_run++;
            if (sd_cyc.size() !== 1 || busy_at[sv_cyc[3] + 1] !== 1'b0) begin
                tests_failed++;
                $display("FAIL seq_done_busy: got %0d seq_done, busy after=%b, expected 1 and 0",
                         sd_cyc.size(), busy_at[sv_cyc[3] + 1]);
            end
        end
    endtask

    task automatic test_timeout();
        int pc1, pc2;
        clear_logs();
        press(2'b01, 8, 30, pc1);
        tests_run++;
        if (to_cyc.size() !== 1 || (to_cyc.size() == 1 && to_cyc[0] !== pc1 + LAT + T)) begin
            tests_failed++;
            $display("FAIL timeout_time: got %0d pulses first=%0d, expected 1 at %0d",
                     to_cyc.size(), (to_cyc.size() > 0) ? to_cyc[0] : -1, pc1 + LAT + T);
        end
        tests_run++;
        if (busy_at[pc1 + LAT + T] !== 1'b1 || busy_at[pc1 + LAT + T + 1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_busy: got %b then %b, expected 1 then 0",
                     busy_at[pc1 + LAT + T], busy_at[pc1 + LAT + T + 1]);
        end
        tests_run++;
        if (dif.bn !== 2'b01) begin
            tests_failed++;
            $display("FAIL timeout_bn_hold: got %b, expected 01", dif.bn);
        end
        press(2'b10, 8, 30, pc2);
        tests_run++;
        if (sv_cyc.size() !== 2 || (sv_cyc.size() == 2 && (sv_idx[1] !== 0 || sv_bn[1] !== 2))) begin
            tests_failed++;
            $display("FAIL timeout_restart: got %0d sym_valid, expected 2 with idx 0 bn 2", sv_cyc.size());
        end
    endtask

    task automatic test_long_hold();
        clear_logs();
        dif.btn_raw = 2'b01;
        tick(2);
        dif.btn_enter_raw = 1'b1;
        tick(10);
        dif.btn_raw = 2'b11;
        tick(30);
        dif.btn_raw = 2'b00;
        tick(60);
        dif.btn_enter_raw = 1'b0;
        tick(20);
        tests_run++;
        if (sv_cyc.size() !== 1 || (sv_cyc.size() == 1 && sv_bn[0] !== 1)) begin
            tests_failed++;
            $display("FAIL long_hold: got %0d sym_valid first bn=%0d, expected 1 with bn 1",
                     sv_cyc.size(), (sv_cyc.size() > 0) ? sv_bn[0] : -1);
        end
        tests_run++;
        if (dif.bn !== 2'b01) begin
            tests_failed++;
            $display("FAIL long_hold_bn: got %b after release, expected 01", dif.bn);
        end
    endtask

    task automatic test_reset_mid();
        int pc;
        press(2'b10, 8, 6, pc);
        press(2'b11, 8, 6, pc);
        tests_run++;
        if (dif.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_pre: got busy=%b, expected 1", dif.busy);
        end
        @(negedge clock);
        #2 clear_n = 1'b0;
        #1;
        tests_run++;
        if ({dif.bn, dif.sym_valid, dif.sym_idx, dif.seq_done, dif.entry_timeout, dif.busy} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_async: got bn=%b v=%b idx=%0d sd=%b to=%b busy=%b, expected all 0",
                     dif.bn, dif.sym_valid, dif.sym_idx, dif.seq_done, dif.entry_timeout, dif.busy);
        end
        #9 clear_n = 1'b1;
        @(negedge clock);
        clear_logs();
        press(2'b01, 8, 30, pc);
        tests_run++;
        if (sv_cyc.size() !== 1 || (sv_cyc.size() == 1 && (sv_idx[0] !== 0 || sv_cyc[0] !== pc + LAT))) begin
            tests_failed++;
            $display("FAIL reset_mid_next: got %0d sym_valid, expected 1 at cyc %0d idx 0", sv_cyc.size(), pc + LAT);
        end
        tests_run++;
        if (to_cyc.size() !== 1 || (to_cyc.size() == 1 && to_cyc[0] !== pc + LAT + T)) begin
            tests_failed++;
            $display("FAIL reset_mid_timeout: got %0d pulses, expected 1 at %0d", to_cyc.size(), pc + LAT + T);
        end
    endtask

    task automatic test_race();
        int pc1, pc2;
        clear_logs();
        press(2'b11, 8, 10, pc1);
        press(2'b01, 8, 30, pc2);
        tests_run++;
        if (sv_cyc.size() !== 2) begin
            tests_failed++;
            $display("FAIL race_count: got %0d sym_valid, expected 2", sv_cyc.size());
        end else begin
            tests_run++;
            if (sv_cyc[1] - sv_cyc[0] !== T || sv_idx[1] !== 1) begin
                tests_failed++;
                $display("FAIL race_commit: got spacing=%0d idx=%0d, expected %0d and 1",
                         sv_cyc[1] - sv_cyc[0], sv_idx[1], T);
            end
            tests_run++;
            if (to_cyc.size() !== 1 || (to_cyc.size() == 1 && to_cyc[0] !== sv_cyc[1] + T)) begin
                tests_failed++;
                $display("FAIL race_timer_restart: got %0d pulses first=%0d, expected 1 at %0d",
                         to_cyc.size(), (to_cyc.size() > 0) ? to_cyc[0] : -1, sv_cyc[1] + T);
            end
        end
    endtask

    task automatic test_random();
        int press_cyc[$];
        int codes[$];
        int exp_sv[$], exp_idx[$], exp_sd[$], exp_to[$];
        int pos, last, n;
        clear_logs();
        for (int i = 0; i < 24; i++) begin
            logic [2:1] code;
            code = 2'($urandom_range(0, 3));
            dif.btn_raw = code;
            tick(2);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) begin
                    dif.btn_enter_raw = 1'b1; tick($urandom_range(1, 2));
                    dif.btn_enter_raw = 1'b0; tick($urandom_range(1, 2));
                end
            end
            dif.btn_enter_raw = 1'b1;
            press_cyc.push_back(cyc);
            codes.push_back(int'(code));
            tick($urandom_range(D + 2, 12));
            dif.btn_enter_raw = 1'b0;
            dif.btn_raw = 2'b00;
            tick($urandom_range(6, 28));
        end
        tick(40);

        // Reference: position counts commits since the last completed or abandoned code.
        pos = 0;
        last = 0;
        foreach (press_cyc[i]) begin
            int c;
            c = press_cyc[i] + LAT;
            if (pos > 0 && c - last > T) begin
                exp_to.push_back(last + T);
                pos = 0;
            end
            exp_sv.push_back(c);
            exp_idx.push_back(pos);
            exp_sd.push_back(int'(pos == S - 1));
            pos = (pos + 1) % S;
            last = c;
        end
        if (pos > 0) exp_to.push_back(last + T);

        tests_run++;
        if (sv_cyc.size() !== exp_sv.size() || to_cyc.size() !== exp_to.size()) begin
            tests_failed++;
            $display("FAIL rand_counts: got %0d commits %0d timeouts, expected %0d and %0d",
                     sv_cyc.size(), to_cyc.size(), exp_sv.size(), exp_to.size());
        end
        n = (sv_cyc.size() < exp_sv.size()) ? sv_cyc.size() : exp_sv.size();
        for (int i = 0; i < n; i++) begin
            tests_run++;
            if (sv_cyc[i] !== exp_sv[i] || sv_bn[i] !== codes[i] ||
                sv_idx[i] !== exp_idx[i] || sv_sd[i] !== exp_sd[i]) begin
                tests_failed++;
                $display("FAIL rand_sym%0d: got cyc=%0d bn=%0d idx=%0d sd=%0d, expected cyc=%0d bn=%0d idx=%0d sd=%0d",
                         i, sv_cyc[i], sv_bn[i], sv_idx[i], sv_sd[i],
                         exp_sv[i], codes[i], exp_idx[i], exp_sd[i]);
            end
        end
        n = (to_cyc.size() < exp_to.size()) ? to_cyc.size() : exp_to.size();
        for (int i = 0; i < n; i++) begin
            tests_run++;
            if (to_cyc[i] !== exp_to[i]) begin
                tests_failed++;
                $display("FAIL rand_timeout%0d: got cyc=%0d, expected cyc=%0d", i, to_cyc[i], exp_to[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_sequence();
        test_timeout();
        test_long_hold();
        test_reset_mid();
        test_race();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
